// File: rtl/seg_scan_controller.sv
// Seven-segment scan controller: prescaled digit scan, frame-aligned page select,
// PWM brightness and leading-zero blanking, all outputs registered.
module seg_scan_controller #(
  parameter  int DIGITS   = 4,
  parameter  int TICK_DIV = 100000,
  parameter  int PWM_W    = 4,
  localparam int IDX_W    = $clog2(DIGITS)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  page_sel,
  input  logic [4*DIGITS-1:0]   page_a,
  input  logic [4*DIGITS-1:0]   page_b,
  input  logic [DIGITS-1:0]     flags_a,
  input  logic [DIGITS-1:0]     flags_b,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  lz_blank,
  input  logic [PWM_W-1:0]      bright,
  output logic [DIGITS-1:0]     an,
  output logic [3:0]            num,
  output logic                  flag,
  output logic                  dp_out,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_start
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PWM_W-1:0]    pwm_q, pwm_d;
  logic                pg_q, pg_d;
  logic                fs_q, fs_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [3:0]          num_q, num_d;
  logic                flag_q, flag_d;
  logic                dp_q, dp_d;

  logic                tick;
  logic                wrap;
  logic [4*DIGITS-1:0] cur_nib;
  logic [DIGITS-1:0]   cur_flags;
  logic [DIGITS-1:0]   nz;
  logic                any_nz;
  logic                blank;
  logic                lit;

  // Scan timing and the page latch; the page only moves on the wrapping tick.
  always_comb begin
    tick  = (pre_q == PRE_LAST);
    wrap  = tick && (idx_q == IDX_LAST);
    pre_d = tick ? '0 : pre_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
    pg_d  = wrap ? page_sel : pg_q;
    fs_d  = wrap;
    pwm_d = pwm_q + 1'b1;
  end

  // Blanking looks at the current digit and every more significant one.
  always_comb begin
    cur_nib   = pg_q ? page_b : page_a;
    cur_flags = pg_q ? flags_b : flags_a;
    nz        = '0;
    any_nz    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      nz[i] = (|cur_nib[4*i +: 4]) | cur_flags[i];
    end
    for (int j = 0; j < DIGITS; j++) begin
      if ((j >= int'(idx_q)) && nz[j]) begin
        any_nz = 1'b1;
      end
    end
    blank = lz_blank && (idx_q != '0) && !any_nz;
    lit   = (pwm_q <= bright);
  end

  always_comb begin
    an_d   = (lit && !blank) ? ~(DIGITS'(1) << idx_q) : '1;
    num_d  = cur_nib[{idx_q, 2'b00} +: 4];
    flag_d = cur_flags[idx_q];
    dp_d   = dp_mask[idx_q] && lit && !blank;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_q  <= '0;
      idx_q  <= '0;
      pwm_q  <= '0;
      pg_q   <= 1'b0;
      fs_q   <= 1'b0;
      an_q   <= '1;
      num_q  <= '0;
      flag_q <= 1'b0;
      dp_q   <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      pwm_q  <= pwm_d;
      pg_q   <= pg_d;
      fs_q   <= fs_d;
      an_q   <= an_d;
      num_q  <= num_d;
      flag_q <= flag_d;
      dp_q   <= dp_d;
    end
  end

  assign an          = an_q;
  assign num         = num_q;
  assign flag        = flag_q;
  assign dp_out      = dp_q;
  assign digit_idx   = idx_q;
  assign frame_start = fs_q;

endmodule
